// File: rtl/layer_norm_pkg.sv
// Shared types, constants and helpers for the sequential LayerNorm controller.
// Also carries the golden integer square root used by the reference model.
package layer_norm_pkg;

  typedef enum logic [2:0] {
    LN_LOAD = 3'd0,
    LN_MEAN = 3'd1,
    LN_VAR  = 3'd2,
    LN_VDIV = 3'd3,
    LN_SQRT = 3'd4,
    LN_NORM = 3'd5
  } ln_state_e;

  localparam int LN_SCALE      = 128;
  localparam int LN_SQRT_ITERS = 4;

  // Clamp a wide signed value into the range of a dw-bit signed integer.
  function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] x, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Newton-Raphson isqrt: seed var/2 (at least 1), then a fixed number of refinements.
  function automatic longint ln_isqrt_golden(input longint v);
    longint g;
    if (v <= 0) return 0;
    g = v >>> 1;
    if (g == 0) g = 1;
    for (int k = 0; k < LN_SQRT_ITERS; k++) g = (g + v / g) >>> 1;
    return g;
  endfunction

endpackage

// File: rtl/ln_isqrt_seq.sv
// Sequential Newton-Raphson square root: one seed cycle on start, then four
// refinement cycles with one divide each; done flags the final refinement cycle.
module ln_isqrt_seq
  import layer_norm_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] var_in,
  output logic signed [W-1:0] root,
  output logic                done
);

  logic signed [W-1:0] v_q;
  logic signed [W-1:0] g_q;
  logic [2:0]          iter_q;
  logic signed [W-1:0] half;
  logic signed [W-1:0] g_init;
  logic signed [W-1:0] div_g;
  logic signed [W-1:0] g_next;

  // NOTE: if/else rather than ?: with '0 keeps these expressions signed.
  always_comb begin
    half = var_in >>> 1;
    if (var_in == '0)    g_init = '0;
    else if (half == '0) g_init = W'(1);
    else                 g_init = half;
    if (g_q == '0) div_g = W'(1);
    else           div_g = g_q;
    g_next = (g_q + v_q / div_g) >>> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      g_q    <= '0;
      iter_q <= '0;
    end else if (start) begin
      v_q    <= var_in;
      g_q    <= g_init;
      iter_q <= 3'(LN_SQRT_ITERS);
    end else if (iter_q != '0) begin
      if (v_q != '0) g_q <= g_next;
      iter_q <= iter_q - 3'd1;
    end
  end

  assign done = (iter_q == 3'd1);
  assign root = g_q;

endmodule

// File: rtl/layer_norm_seq_ctrl.sv
// LayerNorm sequencer: LOAD -> MEAN -> VAR -> VDIV -> SQRT -> NORM over one N-element vector.
// Optional feature: define LN_SAT_CNT_EN to add the sat_cnt port and saturation counter.
module layer_norm_seq_ctrl
  import layer_norm_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic signed [ACC_WIDTH-1:0]  stddev_o
`ifdef LN_SAT_CNT_EN
  ,
  output logic [$clog2(N+1)-1:0]       sat_cnt
`endif
);

  localparam int IW = $clog2(N);
  localparam logic [2:0] ST_LOAD = LN_LOAD;
  localparam logic [2:0] ST_MEAN = LN_MEAN;
  localparam logic [2:0] ST_VAR  = LN_VAR;
  localparam logic [2:0] ST_VDIV = LN_VDIV;
  localparam logic [2:0] ST_SQRT = LN_SQRT;
  localparam logic [2:0] ST_NORM = LN_NORM;
  localparam logic signed [ACC_WIDTH-1:0] N_S     = ACC_WIDTH'(N);
  localparam logic signed [ACC_WIDTH-1:0] SCALE_S = ACC_WIDTH'(LN_SCALE);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [2:0]                  state;
  logic [IW-1:0]               idx;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] mean;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] var_q;
  logic                        sqrt_start;
  logic                        sqrt_done;
  logic signed [ACC_WIDTH-1:0] std;
  logic signed [DATA_WIDTH-1:0] vec_buf [N];

  logic                        in_hs;
  logic                        out_hs;
  logic signed [ACC_WIDTH-1:0] diff;
  logic signed [ACC_WIDTH-1:0] num;
  logic signed [ACC_WIDTH-1:0] quo;
  logic signed [63:0]          quo_sat;

  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_NORM);
  assign out_last  = out_valid && (idx == LAST_IDX);
  assign busy      = !((state == ST_LOAD) && (idx == '0));
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign stddev_o  = std;

  // Centered element feeds both the variance accumulation and the normalize divider.
  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    diff = ACC_WIDTH'(vec_buf[idx]) - mean;
    num  = diff * SCALE_S;
    if (std == '0) quo = '0;
    else           quo = num / std;
    quo_sat  = sat_to_dw(64'(quo), DATA_WIDTH);
    out_data = '0;
    if (out_valid) out_data = DATA_WIDTH'(quo_sat);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      idx        <= '0;
      sum        <= '0;
      mean       <= '0;
      acc        <= '0;
      var_q      <= '0;
      sqrt_start <= 1'b0;
    end else begin
      sqrt_start <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (in_hs) begin
            sum <= sum + ACC_WIDTH'(in_data);
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= ST_MEAN;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        ST_MEAN: begin
          mean  <= sum / N_S;
          sum   <= '0;
          acc   <= '0;
          state <= ST_VAR;
        end
        ST_VAR: begin
          acc <= acc + diff * diff;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= ST_VDIV;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_VDIV: begin
          var_q      <= acc / N_S;
          sqrt_start <= 1'b1;
          state      <= ST_SQRT;
        end
        ST_SQRT: begin
          if (sqrt_done) state <= ST_NORM;
        end
        ST_NORM: begin
          if (out_hs) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= ST_LOAD;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // NOTE: the vector buffer has no reset; LOAD rewrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (in_hs) vec_buf[idx] <= in_data;
  end

`ifdef LN_SAT_CNT_EN
  logic sat_hit;
  assign sat_hit = (quo_sat != 64'(quo));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          sat_cnt <= '0;
    else if (state == ST_SQRT && sqrt_done) sat_cnt <= '0;
    else if (out_hs && sat_hit)          sat_cnt <= sat_cnt + ($clog2(N+1))'(1);
  end
`endif

  ln_isqrt_seq #(
    .W(ACC_WIDTH)
  ) u_isqrt (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (sqrt_start),
    .var_in (var_q),
    .root   (std),
    .done   (sqrt_done)
  );

endmodule

// File: tb/tb_layer_norm_seq_ctrl.sv
// Self-checking bench for layer_norm_seq_ctrl: arithmetic reference model plus literal expectations.
// Honors LN_SAT_CNT_EN when the design is built with the saturation counter.
module tb_layer_norm_seq_ctrl;
  import layer_norm_pkg::*;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 32;

  typedef int vec_t [N];
  typedef struct {
    int data;
    bit last;
    int std;
    int sat_before;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;
  logic                 busy;
  logic signed [AW-1:0] stddev_o;
`ifdef LN_SAT_CNT_EN
  logic [$clog2(N+1)-1:0] sat_cnt;
`endif

  layer_norm_seq_ctrl #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .stddev_o  (stddev_o)
`ifdef LN_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_in_cyc = 0;
  int   n_hs = 0;
  int   std_seen = 0;
  int   ready_mode = 0;
  bit   prev_valid = 0;
  exp_t exp_q [$];
  int   got_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Reference: plain integer arithmetic over the whole vector.
  function automatic void push_expect(input vec_t v);
    int   s, mean, a, var_v, std, q, sat;
    exp_t e;
    s = 0;
    for (int i = 0; i < N; i++) s += v[i];
    mean = s / N;
    a = 0;
    for (int i = 0; i < N; i++) a += (v[i] - mean) * (v[i] - mean);
    var_v = a / N;
    std = int'(ln_isqrt_golden(longint'(var_v)));
    sat = 0;
    for (int i = 0; i < N; i++) begin
      q = (std == 0) ? 0 : ((v[i] - mean) * LN_SCALE) / std;
      e.data = (q > 127) ? 127 : ((q < -128) ? -128 : q);
      e.last = (i == N - 1);
      e.std = std;
      e.sat_before = sat;
      exp_q.push_back(e);
      if (q > 127 || q < -128) sat++;
    end
  endfunction

  // Single compare process: every cycle with out_valid is checked against the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) last_in_cyc = cyc + 1;
      if (out_valid) begin
        if (!prev_valid) check("first_out_latency", cyc - last_in_cyc, N + 7);
        check("in_ready_low_in_norm", in_ready, 0);
        check("busy_in_norm", busy, 1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got data %0d with no expected element", out_data);
        end else begin
          e = exp_q[0];
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
          check("stddev_o", stddev_o, e.std);
`ifdef LN_SAT_CNT_EN
          check("sat_cnt_running", sat_cnt, e.sat_before);
`endif
          std_seen = stddev_o;
          if (out_ready) begin
            void'(exp_q.pop_front());
            got_q.push_back(int'(out_data));
            n_hs++;
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send_vec(input vec_t v);
    int waited;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(v[i]);
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) check("in_accept_timeout", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!(got_q.size() == N && exp_q.size() == 0) && k < 2000) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("vector_output_count", got_q.size(), N);
    @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  task automatic run_vec(input vec_t v, input vec_t lit, input int lit_std, input int lit_sat, input bit garbage);
    int k;
    exp_q.delete();
    got_q.delete();
    n_hs = 0;
    push_expect(v);
    send_vec(v);
    if (garbage) begin
      // Inputs offered while busy must not be consumed.
      in_valid = 1'b1;
      in_data  = 8'sd100;
      k = 0;
      while (!out_valid && k < 100) begin
        @(negedge clk);
        #2;
        k++;
      end
      in_valid = 1'b0;
    end
    wait_done();
    for (int i = 0; i < N && i < got_q.size(); i++) check("literal_out", got_q[i], lit[i]);
    check("literal_std", std_seen, lit_std);
`ifdef LN_SAT_CNT_EN
    check("literal_sat_cnt", sat_cnt, lit_sat);
`else
    if (lit_sat < 0) check("literal_sat_unused", lit_sat, 0);
`endif
  endtask

  initial begin
    vec_t v_zero, v_alt, v_ramp, v_small;
    vec_t l_zero, l_alt, l_ramp;
    int k;
    v_zero  = '{0, 0, 0, 0, 0, 0, 0, 0};
    v_alt   = '{-4, 4, -4, 4, -4, 4, -4, 4};
    v_ramp  = '{1, 2, 3, 4, 5, 6, 7, 8};
    v_small = '{-1, -2, 0, 0, 0, 0, 0, 0};
    l_zero  = '{0, 0, 0, 0, 0, 0, 0, 0};
    l_alt   = '{-128, 127, -128, 127, -128, 127, -128, 127};
    l_ramp  = '{-128, -128, -64, 0, 64, 127, 127, 127};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_stddev", stddev_o, 0);
`ifdef LN_SAT_CNT_EN
    check("rst_sat_cnt", sat_cnt, 0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_vec(v_zero, l_zero, 0, 0, 1'b0);
    run_vec(v_alt, l_alt, 4, 4, 1'b0);
    run_vec(v_ramp, l_ramp, 2, 4, 1'b0);
    run_vec(v_small, l_zero, 0, 0, 1'b1);

    ready_mode = 1;
    run_vec(v_ramp, l_ramp, 2, 4, 1'b0);
    ready_mode = 0;

    // Abort mid-NORM while element 3 is presented, then run a clean vector.
    exp_q.delete();
    got_q.delete();
    n_hs = 0;
    push_expect(v_ramp);
    send_vec(v_ramp);
    k = 0;
    while (n_hs < 3 && k < 500) begin
      @(negedge clk);
      #2;
      k++;
    end
    ready_mode = 2;
    check("reached_element_3", n_hs, 3);
    @(negedge clk);
    #2;
    check("presenting_element_3", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_stddev", stddev_o, 0);
    exp_q.delete();
    got_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    run_vec(v_alt, l_alt, 4, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
